// File: rtl/param_sync_fifo_pkg.sv
// fifo_pkg: shared defaults and status bundle for param_sync_fifo.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_AE_LEVEL   = 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;
endpackage

// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: write/read handshake and status bundle of param_sync_fifo.
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);
    logic                  w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, r_en, data_in,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  w_en, r_en, data_in,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ptr_ctr.sv
// fifo_ptr_ctr: modulo-DEPTH wrapping pointer with increment enable.
module fifo_ptr_ctr #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc_i,
    output logic [$clog2(DEPTH)-1:0] ptr_o
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb ptr_d = !inc_i ? ptr_q : (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;

    assign ptr_o = ptr_q;
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: synchronous FIFO with any DEPTH >= 2 and almost/over/underflow flags.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is 1-cycle registered read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input logic               clk,
    input logic               rst_n,
    param_sync_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_acc, rd_acc;
    fifo_status_t          st;

    // Flags are pure functions of the registered count, so they settle right after each edge.
    assign st.full         = count_q == CW'(DEPTH);
    assign st.empty        = count_q == '0;
    assign st.almost_full  = count_q >= CW'(AF_LEVEL);
    assign st.almost_empty = count_q <= CW'(AE_LEVEL);
    assign st.overflow     = ovf_q;
    assign st.underflow    = unf_q;

    assign wr_acc = bus.w_en && (!st.full || bus.r_en);
    assign rd_acc = bus.r_en && !st.empty;

    always_comb begin
        count_d = (wr_acc && !rd_acc) ? count_q + CW'(1) :
                  (rd_acc && !wr_acc) ? count_q - CW'(1) : count_q;
        ovf_d   = bus.w_en && st.full && !bus.r_en;
        unf_d   = bus.r_en && st.empty;
    end

    fifo_ptr_ctr #(.DEPTH(DEPTH)) u_wptr (.clk(clk), .rst_n(rst_n), .inc_i(wr_acc), .ptr_o(wptr));
    fifo_ptr_ctr #(.DEPTH(DEPTH)) u_rptr (.clk(clk), .rst_n(rst_n), .inc_i(rd_acc), .ptr_o(rptr));

    // Storage is intentionally not reset; count guards every read of it.
    always_ff @(posedge clk)
        if (wr_acc) mem_q[wptr] <= bus.data_in;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign bus.data_out = st.empty ? '0 : mem_q[rptr];
`else
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb dout_d = rd_acc ? mem_q[rptr] : dout_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;

    assign bus.data_out = dout_q;
`endif

    assign bus.full         = st.full;
    assign bus.empty        = st.empty;
    assign bus.almost_full  = st.almost_full;
    assign bus.almost_empty = st.almost_empty;
    assign bus.overflow     = st.overflow;
    assign bus.underflow    = st.underflow;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: self-checking bench for param_sync_fifo (DEPTH 8, DEPTH 5, DEPTH 8 with AF=6/AE=2).
// Honours PARAM_SYNC_FIFO_FWFT_EN for the data_out expectations.
module tb_param_sync_fifo;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) b8 ();
    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(5)) b5 ();
    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) ba ();

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5));
    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) ua (.clk(clk), .rst_n(rst_n), .bus(ba));

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        int         cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t       tv[$];
    logic [7:0] sb0[$], sb1[$], sb2[$];
    int         dep[3] = '{8, 5, 8};
    int         mc[3];
    logic [7:0] lastd[3];
    int         n_pass = 0;
    int         n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void add(input logic w, input logic r, input logic [7:0] d,
                                input int c, input logic o, input logic u);
        tv.push_back('{w, r, d, c, c == 8, c == 0, c >= 7, c <= 1, o, u});
    endfunction

    function automatic int dout(input int k);
        case (k)
            0: return int'(b8.data_out);
            1: return int'(b5.data_out);
            default: return int'(ba.data_out);
        endcase
    endfunction

    function automatic int cnt(input int k);
        case (k)
            0: return int'(b8.count);
            1: return int'(b5.count);
            default: return int'(ba.count);
        endcase
    endfunction

    function automatic void push(input int k, input logic [7:0] d);
        case (k)
            0: sb0.push_back(d);
            1: sb1.push_back(d);
            default: sb2.push_back(d);
        endcase
    endfunction

    function automatic logic [7:0] pop(input int k);
        case (k)
            0: return sb0.pop_front();
            1: return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    function automatic logic [7:0] head(input int k);
        case (k)
            0: return sb0[0];
            1: return sb1[0];
            default: return sb2[0];
        endcase
    endfunction

    function automatic void set_in(input int k, input logic w, input logic r, input logic [7:0] d);
        b8.w_en = (k == 0) && w; b8.r_en = (k == 0) && r; b8.data_in = d;
        b5.w_en = (k == 1) && w; b5.r_en = (k == 1) && r; b5.data_in = d;
        ba.w_en = (k == 2) && w; ba.r_en = (k == 2) && r; ba.data_in = d;
    endfunction

    function automatic void model_reset();
        sb0.delete(); sb1.delete(); sb2.delete();
        mc    = '{0, 0, 0};
        lastd = '{8'h00, 8'h00, 8'h00};
    endfunction

    // One clock of stimulus on instance k; the queue model predicts acceptance and read data.
    task automatic drive(input int k, input logic w, input logic r, input logic [7:0] d);
        logic       wa, ra;
        logic [7:0] e;
        e = 8'h00;
        set_in(k, w, r, d);
        wa = w && (mc[k] < dep[k] || r);
        ra = r && mc[k] > 0;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check("fwft_head", dout(k), mc[k] > 0 ? int'(head(k)) : 0);
`endif
        if (ra) e = pop(k);
        if (wa) push(k, d);
        mc[k] = mc[k] + int'(wa) - int'(ra);
        @(posedge clk);
        #1;
`ifndef PARAM_SYNC_FIFO_FWFT_EN
        if (ra) lastd[k] = e;
        check("data_out", dout(k), int'(lastd[k]));
`endif
        check("count_model", cnt(k), mc[k]);
        set_in(k, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 1'b0, 1'b0, 8'h00);
        model_reset();
        #2;
        check("rst_empty", b8.empty, 1);
        check("rst_aempty", b8.almost_empty, 1);
        check("rst_full", b8.full, 0);
        check("rst_afull", b8.almost_full, 0);
        check("rst_count", b8.count, 0);
        check("rst_ovf", b8.overflow, 0);
        check("rst_unf", b8.underflow, 0);
        check("rst_dout", b8.data_out, 0);
        check("rst_empty5", b5.empty, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Fill, overflow, drain, underflow, both-on-empty, refill, both-on-full.
        for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 8'(i), i, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h99, 8, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 8, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) add(1'b0, 1'b1, 8'h00, i, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'h40, 1, 1'b0, 1'b1);
        for (int i = 2; i <= 8; i++) add(1'b1, 1'b0, 8'(8'h40 + i), i, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'h50, 8, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 8, 1'b0, 1'b0);

        foreach (tv[i]) begin
            drive(0, tv[i].w, tv[i].r, tv[i].d);
            check($sformatf("v%0d_count", i), b8.count, tv[i].cnt);
            check($sformatf("v%0d_full", i), b8.full, tv[i].full);
            check($sformatf("v%0d_empty", i), b8.empty, tv[i].empty);
            check($sformatf("v%0d_afull", i), b8.almost_full, tv[i].af);
            check($sformatf("v%0d_aempty", i), b8.almost_empty, tv[i].ae);
            check($sformatf("v%0d_ovf", i), b8.overflow, tv[i].ovf);
            check($sformatf("v%0d_unf", i), b8.underflow, tv[i].unf);
        end

        // DEPTH=5: fill, stream across pointer wrap while full, then drain.
        for (int i = 0; i < 5; i++) drive(1, 1'b1, 1'b0, 8'(8'h20 + i));
        check("d5_full", b5.full, 1);
        for (int i = 0; i < 12; i++) begin
            drive(1, 1'b1, 1'b1, 8'(8'h30 + i));
            check("d5_cnt_le5", int'(b5.count <= 3'd5), 1);
            check("d5_no_ovf", b5.overflow, 0);
        end
        for (int i = 0; i < 5; i++) drive(1, 1'b0, 1'b1, 8'h00);
        check("d5_empty", b5.empty, 1);

        // AF_LEVEL=6 / AE_LEVEL=2 thresholds on the way up and down.
        for (int i = 1; i <= 8; i++) begin
            drive(2, 1'b1, 1'b0, 8'(8'h60 + i));
            check($sformatf("af_up%0d", i), ba.almost_full, int'(i >= 6));
            check($sformatf("ae_up%0d", i), ba.almost_empty, int'(i <= 2));
        end
        for (int i = 7; i >= 0; i--) begin
            drive(2, 1'b0, 1'b1, 8'h00);
            check($sformatf("af_dn%0d", i), ba.almost_full, int'(i >= 6));
            check($sformatf("ae_dn%0d", i), ba.almost_empty, int'(i <= 2));
        end

        // Asynchronous reset mid-burst at count 4.
        rst_n = 1'b0;
        #1 model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 1'b0, 8'(8'h70 + i));
        check("pre_rst_count", b8.count, 4);
        b8.w_en = 1'b1;
        b8.data_in = 8'hEE;
        #3 rst_n = 1'b0;
        #1;
        check("arst_count", b8.count, 0);
        check("arst_empty", b8.empty, 1);
        check("arst_aempty", b8.almost_empty, 1);
        check("arst_full", b8.full, 0);
        check("arst_afull", b8.almost_full, 0);
        check("arst_ovf", b8.overflow, 0);
        check("arst_dout", b8.data_out, 0);
        b8.w_en = 1'b0;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 8'hA5);
        check("post_rst_count", b8.count, 1);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check("fwft_a5", b8.data_out, 8'hA5);
`else
        drive(0, 1'b0, 1'b1, 8'h00);
        check("std_a5", b8.data_out, 8'hA5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width in bits of each FIFO word.
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of storage entries; any integer >= 2, not restricted to a power of two.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, meaning count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 1, meaning count at or below which almost_empty asserts.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port w_en, input, 1, write request.
REQ-008 SHALL have port r_en, input, 1, read request.
REQ-009 SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-010 SHALL have port data_out, output, DATA_WIDTH, read data.
REQ-011 SHALL have port full / empty, output, 1 each, occupancy == DEPTH / occupancy == 0.
REQ-012 SHALL have port almost_full / almost_empty, output, 1 each, count >= AF_LEVEL / count <= AE_LEVEL.
REQ-013 SHALL have port count, output, $clog2(DEPTH+1), current occupancy.
REQ-014 SHALL have port overflow / underflow, output, 1 each, one-cycle pulse on a rejected write / rejected read.

Function
REQ-015 SHALL accept a write when w_en && (!full || r_en); accepting a write stores data_in at the write pointer.
REQ-016 SHALL accept a read when r_en && !empty.
REQ-017 SHALL make all DEPTH entries usable; full asserts only at count == DEPTH.
REQ-018 SHALL wrap each pointer from DEPTH-1 to 0, for both power-of-two and non-power-of-two DEPTH.
REQ-019 SHALL update count next cycle: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 SHALL derive full, empty, almost_full and almost_empty as registered-equivalent functions of count, so they are valid the cycle after the causing edge.
REQ-021 SHALL, when full with w_en && r_en both set, accept both; count stays DEPTH and overflow stays 0.
REQ-022 SHALL, when empty with w_en && r_en both set, accept the write, reject the read, and pulse underflow.
REQ-023 SHALL pulse overflow for one cycle on w_en && full && !r_en; storage and pointers are unchanged.
REQ-024 SHALL pulse underflow for one cycle on r_en && empty; data_out is unchanged.
REQ-025 SHALL, in standard mode, register data_out = head entry on the edge a read is accepted (1-cycle latency) and hold it otherwise.

Reset
REQ-026 SHALL, on rst_n low, immediately clear pointers, count, data_out, overflow and underflow, independent of clk.
REQ-027 SHALL drive the following while in reset: empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>0).
REQ-028 SHALL leave storage array contents uninitialised on reset; no reads of them are possible before a write.
REQ-029 SHALL discard any in-progress operation on reset assertion mid-stream; the first edge after deassertion behaves as from empty.

Configuration
REQ-030 SHALL, with PARAM_SYNC_FIFO_FWFT_EN defined, operate first-word-fall-through: data_out = head entry whenever !empty, valid the cycle after the writing edge; an accepted read advances to the next entry with zero read latency.
REQ-031 SHALL, in FWFT mode, hold data_out at 0 while empty.
REQ-032 SHALL, without PARAM_SYNC_FIFO_FWFT_EN, use standard mode (REQ-025) only.

Structure
REQ-033 SHALL take from shared package fifo_pkg: the default-parameter constants, and a typedef fifo_status_t packing full, empty, almost_full, almost_empty, overflow, underflow.
REQ-034 SHALL instantiate sub-module fifo_ptr_ctr (modulo-DEPTH wrapping pointer with increment enable) twice, once for each pointer.

Verification
REQ-035 SHALL cover: DEPTH=8, write 8 words 0x01..0x08 -> full=1 and count=8 after the 8th write; a 9th write pulses overflow and storage is unchanged.
REQ-036 SHALL cover: from full, read 8 times -> data_out sequence 0x01..0x08 one cycle after each r_en; then empty=1; a further read pulses underflow.
REQ-037 SHALL cover: DEPTH=5, stream 12 writes/reads interleaved -> data in order across pointer wrap; count never exceeds 5.
REQ-038 SHALL cover: full with w_en=r_en=1 -> count stays 8, no overflow; empty with both set -> count=1 and underflow pulses.
REQ-039 SHALL cover: AF_LEVEL=6, AE_LEVEL=2 -> almost_full rises at count 6; almost_empty falls at count 3.
REQ-040 SHALL cover: rst_n low mid-burst at count=4, asynchronous to clk -> outputs reach reset values before the next edge; with FWFT_EN defined, a write of 0xA5 gives data_out=0xA5 the next cycle with no r_en.
